// File: rtl/fft_butterfly_twiddle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_butterfly_twiddle_pkg
//  Description : Shared FFT helpers: log2, twiddle format, saturation and
//                round-half-up arithmetic shift.
//  Revision    : 1.0
// ============================================================================
package fft_butterfly_twiddle_pkg;

    function automatic int fft_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Twiddle ROM address width; never below one bit even for a 2-point FFT.
    function automatic int rom_aw(input int points);
        int a;
        a = fft_log2(points / 2);
        return (a < 1) ? 1 : a;
    endfunction

    function automatic int tw_one(input int tw_width);
        return 1 << (tw_width - 2);
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint rnd_shift(input longint v, input int sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
`default_nettype none
// ============================================================================
//  Module      : fft_twiddle_rom
//  Description : Registered twiddle lookup W(m) = cos(2*pi*m/N) - j*sin(2*pi*m/N).
//  Revision    : 1.0
// ============================================================================
module fft_twiddle_rom
    import fft_butterfly_twiddle_pkg::*;
#(
    parameter int points   = 64,
    parameter int tw_width = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_ce,
    input  logic [rom_aw(points)-1:0]  i_addr,
    output logic signed [tw_width-1:0] o_wr,
    output logic signed [tw_width-1:0] o_wi
);

    localparam int  c_depth  = 1 << rom_aw(points);
    localparam real c_one    = 1.0 * tw_one(tw_width);
    localparam real c_two_pi = 6.283185307179586;

    logic signed [tw_width-1:0] w_tab_r [c_depth];
    logic signed [tw_width-1:0] w_tab_i [c_depth];

    // int'() of a real rounds to nearest, giving the quantised coefficient.
    generate
        for (genvar g = 0; g < c_depth; g++) begin : g_entry
            localparam real c_ang = c_two_pi * g / points;
            localparam int  c_re  = int'(c_one * $cos(c_ang));
            localparam int  c_im  = int'(-c_one * $sin(c_ang));
            assign w_tab_r[g] = c_re[tw_width-1:0];
            assign w_tab_i[g] = c_im[tw_width-1:0];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_wr <= '0;
            o_wi <= '0;
        end else if (i_ce) begin
            o_wr <= w_tab_r[i_addr];
            o_wi <= w_tab_i[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_butterfly_twiddle.sv
`default_nettype none
// ============================================================================
//  Module      : fft_butterfly_twiddle
//  Description : Three-stage radix-2 DIF butterfly: x = a+b, y = (a-b)*W.
//  Revision    : 1.0
// ============================================================================
module fft_butterfly_twiddle
    import fft_butterfly_twiddle_pkg::*;
#(
    parameter int width         = 8,
    parameter int period        = 8,
    parameter int points        = 64,
    parameter int counter_width = 32,
    parameter int tw_width      = 8,
    parameter int scale         = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ce,
    input  logic             valid_a,
    input  logic [width-1:0] ar,
    input  logic [width-1:0] ai,
    input  logic             valid_b,
    input  logic [width-1:0] br,
    input  logic [width-1:0] bi,
    output logic             valid_x,
    output logic [width-1:0] xr,
    output logic [width-1:0] xi,
    output logic             valid_y,
    output logic [width-1:0] yr,
    output logic [width-1:0] yi,
    output logic             err
);

    localparam int c_aw         = rom_aw(points);
    localparam int c_stride_log = fft_log2(points / (2 * period));
    localparam int c_pw         = width + 1 + tw_width;

    logic [counter_width-1:0]   r_k;
    logic [c_aw-1:0]            w_addr;
    logic signed [tw_width-1:0] w_wr, w_wi;

    logic signed [width:0]      w_sr, w_si, w_dr, w_di;
    logic signed [width:0]      r_sr1, r_si1, r_dr1, r_di1;
    logic                       r_v1;

    logic signed [c_pw-1:0]     w_dr_ext, w_di_ext, w_wr_ext, w_wi_ext;
    logic signed [c_pw-1:0]     r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [width:0]      r_sr2, r_si2;
    logic                       r_v2;

    // m = k * N/(2*period); the stride is a power of two, so a shift suffices.
    assign w_addr = r_k[c_aw-1:0] << c_stride_log;

    fft_twiddle_rom #(
        .points   (points),
        .tw_width (tw_width)
    ) u_rom (
        .CLK    (CLK),
        .RST    (RST),
        .i_ce   (ce),
        .i_addr (w_addr),
        .o_wr   (w_wr),
        .o_wi   (w_wi)
    );

    assign w_sr = $signed({ar[width-1], ar}) + $signed({br[width-1], br});
    assign w_si = $signed({ai[width-1], ai}) + $signed({bi[width-1], bi});
    assign w_dr = $signed({ar[width-1], ar}) - $signed({br[width-1], br});
    assign w_di = $signed({ai[width-1], ai}) - $signed({bi[width-1], bi});

    assign w_dr_ext = {{tw_width{r_dr1[width]}}, r_dr1};
    assign w_di_ext = {{tw_width{r_di1[width]}}, r_di1};
    assign w_wr_ext = {{(width + 1){w_wr[tw_width-1]}}, w_wr};
    assign w_wi_ext = {{(width + 1){w_wi[tw_width-1]}}, w_wi};

    // Pair counter and sticky leg-mismatch flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_k <= '0;
            err <= 1'b0;
        end else if (ce) begin
            if (valid_a && valid_b)
                r_k <= (r_k == counter_width'(period - 1)) ? '0 : r_k + counter_width'(1);
            else
                r_k <= '0;
            if (valid_a != valid_b)
                err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sr1   <= '0;
            r_si1   <= '0;
            r_dr1   <= '0;
            r_di1   <= '0;
            r_v1    <= 1'b0;
            r_p_rr  <= '0;
            r_p_ii  <= '0;
            r_p_ri  <= '0;
            r_p_ir  <= '0;
            r_sr2   <= '0;
            r_si2   <= '0;
            r_v2    <= 1'b0;
            xr      <= '0;
            xi      <= '0;
            yr      <= '0;
            yi      <= '0;
            valid_x <= 1'b0;
            valid_y <= 1'b0;
        end else if (ce) begin
            r_sr1  <= (scale != 0) ? (w_sr >>> 1) : w_sr;
            r_si1  <= (scale != 0) ? (w_si >>> 1) : w_si;
            r_dr1  <= (scale != 0) ? (w_dr >>> 1) : w_dr;
            r_di1  <= (scale != 0) ? (w_di >>> 1) : w_di;
            r_v1   <= valid_a && valid_b;

            r_p_rr <= w_dr_ext * w_wr_ext;
            r_p_ii <= w_di_ext * w_wi_ext;
            r_p_ri <= w_dr_ext * w_wi_ext;
            r_p_ir <= w_di_ext * w_wr_ext;
            r_sr2  <= r_sr1;
            r_si2  <= r_si1;
            r_v2   <= r_v1;

            xr <= width'(sat(longint'(r_sr2), width));
            xi <= width'(sat(longint'(r_si2), width));
            yr <= width'(sat(rnd_shift(longint'(r_p_rr) - longint'(r_p_ii), tw_width - 2), width));
            yi <= width'(sat(rnd_shift(longint'(r_p_ri) + longint'(r_p_ir), tw_width - 2), width));
            valid_x <= r_v2;
            valid_y <= r_v2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_butterfly_twiddle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_butterfly_twiddle
//  Description : Scoreboard bench for scaled and unscaled butterfly instances.
//  Revision    : 1.0
// ============================================================================
module tb_fft_butterfly_twiddle;

    localparam int c_p   = 4;
    localparam int c_n   = 8;
    localparam int c_inf = 1 << 30;

    typedef struct {
        int due;
        int xr, xi, yr, yi;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ce = 1'b0, va = 1'b0, vb = 1'b0;
    logic signed [7:0] ar = '0, ai = '0, br = '0, bi = '0;

    logic v1x, v1y, e1, v0x, v0y, e0;
    logic signed [7:0] x1r, x1i, y1r, y1i, x0r, x0i, y0r, y0i;

    exp_t q1[$];
    exp_t q0[$];
    int   checks = 0, errors = 0;
    int   cnt = 0, k_m = 0, err_edge = c_inf;
    bit   ce_prev = 1'b0;
    logic [34:0] snap1, snap0, prev1 = '0, prev0 = '0;

    assign snap1 = {v1x, v1y, e1, x1r, x1i, y1r, y1i};
    assign snap0 = {v0x, v0y, e0, x0r, x0i, y0r, y0i};

    always #5 CLK = ~CLK;

    fft_butterfly_twiddle #(
        .width(8), .period(c_p), .points(c_n), .counter_width(32), .tw_width(8), .scale(1)
    ) dut1 (
        .CLK(CLK), .RST(RST), .ce(ce),
        .valid_a(va), .ar(ar), .ai(ai), .valid_b(vb), .br(br), .bi(bi),
        .valid_x(v1x), .xr(x1r), .xi(x1i), .valid_y(v1y), .yr(y1r), .yi(y1i), .err(e1)
    );

    fft_butterfly_twiddle #(
        .width(8), .period(c_p), .points(c_n), .counter_width(32), .tw_width(8), .scale(0)
    ) dut0 (
        .CLK(CLK), .RST(RST), .ce(ce),
        .valid_a(va), .ar(ar), .ai(ai), .valid_b(vb), .br(br), .bi(bi),
        .valid_x(v0x), .xr(x0r), .xi(x0i), .valid_y(v0y), .yr(y0r), .yi(y0i), .err(e0)
    );

    function automatic int satw(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    // Reference: complex add/sub, optional halving, quantised W, round-half-up.
    function automatic exp_t model(input int a_r, a_i, b_r, b_i, k, sc, due);
        exp_t e;
        int sr, si, dr, di, m, wr, wi;
        real ang;
        sr = a_r + b_r; si = a_i + b_i; dr = a_r - b_r; di = a_i - b_i;
        if (sc != 0) begin
            sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
        end
        m   = k * (c_n / (2 * c_p));
        ang = 6.283185307179586 * m / c_n;
        wr  = int'(64.0 * $cos(ang));
        wi  = int'(-64.0 * $sin(ang));
        e.due = due;
        e.xr  = satw(sr);
        e.xi  = satw(si);
        e.yr  = satw((dr * wr - di * wi + 32) >>> 6);
        e.yi  = satw((dr * wi + di * wr + 32) >>> 6);
        return e;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic check_out(input string nm, input bit have, input exp_t e,
                             input logic vx, vy, input logic signed [7:0] xr_, xi_, yr_, yi_);
        chk({nm, "_valid_x"}, vx, have);
        chk({nm, "_valid_y"}, vy, have);
        if (have) begin
            chk({nm, "_xr"}, xr_, e.xr);
            chk({nm, "_xi"}, xi_, e.xi);
            chk({nm, "_yr"}, yr_, e.yr);
            chk({nm, "_yi"}, yi_, e.yi);
        end
    endtask

    // One input cycle: push expectations, then cross the clock edge.
    task automatic step(input bit c, input bit a_v, input bit b_v,
                        input int a_r, a_i, b_r, b_i);
        ce = c; va = a_v; vb = b_v;
        ar = 8'(a_r); ai = 8'(a_i); br = 8'(b_r); bi = 8'(b_i);
        if (c) begin
            if (a_v && b_v) begin
                q1.push_back(model(a_r, a_i, b_r, b_i, k_m, 1, cnt + 3));
                q0.push_back(model(a_r, a_i, b_r, b_i, k_m, 0, cnt + 3));
                k_m = (k_m + 1) % c_p;
            end else begin
                k_m = 0;
            end
            if (a_v != b_v && err_edge == c_inf) err_edge = cnt + 1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic rnd_steps(input int n, input bit allow_freeze);
        for (int i = 0; i < n; i++) begin
            bit c, v;
            c = allow_freeze ? ($urandom_range(0, 9) < 8) : 1'b1;
            v = ($urandom_range(0, 7) != 0);
            step(c, v, v, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                 $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        end
    endtask

    always @(posedge CLK) begin
        ce_prev = ce && !RST;
        if (ce && !RST) cnt++;
    end

    always @(negedge CLK) begin
        exp_t e1x, e0x;
        bit   h1, h0;
        if (RST) begin
            chk("rst_valid_x1", v1x, 0); chk("rst_valid_y1", v1y, 0); chk("rst_err1", e1, 0);
            chk("rst_valid_x0", v0x, 0); chk("rst_valid_y0", v0y, 0); chk("rst_err0", e0, 0);
        end else if (!ce_prev) begin
            chk("hold1", snap1, prev1);
            chk("hold0", snap0, prev0);
        end else begin
            h1 = 1'b0; h0 = 1'b0;
            if (q1.size() > 0 && q1[0].due == cnt) begin e1x = q1.pop_front(); h1 = 1'b1; end
            if (q0.size() > 0 && q0[0].due == cnt) begin e0x = q0.pop_front(); h0 = 1'b1; end
            check_out("scaled", h1, e1x, v1x, v1y, x1r, x1i, y1r, y1i);
            check_out("unscaled", h0, e0x, v0x, v0y, x0r, x0i, y0r, y0i);
            chk("err1", e1, cnt >= err_edge);
            chk("err0", e0, cnt >= err_edge);
        end
        prev1 = snap1;
        prev0 = snap0;
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0);

        // k = 0..3 back to back, bubble, then k restarts at 0.
        for (int i = 0; i < 4; i++) step(1, 1, 1, 10, 0, 6, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 10, 0, 6, 0);
        step(1, 1, 1, 100, -100, 100, -100);
        step(1, 1, 1, -128, 127, 127, -128);
        step(1, 1, 1, -128, -128, -128, -128);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);

        rnd_steps(150, 1'b1);

        // Freeze mid-stream for five cycles.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 20 * i, -7 * i, 5, 33);
        for (int i = 0; i < 5; i++) step(0, i[0], 1, 99, 99, -99, -99);
        for (int i = 0; i < 4; i++) step(1, 1, 1, -3 * i, 50, 17, -20 * i);

        // Leg mismatch: sticky err, k cleared for the next pair.
        step(1, 1, 1, 40, 40, 2, 2);
        step(1, 1, 0, 1, 2, 3, 4);
        step(1, 1, 1, 10, 0, 6, 0);
        rnd_steps(40, 1'b0);

        // Asynchronous reset with pairs in flight.
        step(1, 1, 1, 70, -30, 10, 90);
        step(1, 1, 1, -60, 20, 55, -5);
        #2;
        RST = 1'b1;
        #1;
        chk("async_valid_x1", v1x, 0); chk("async_valid_y1", v1y, 0);
        chk("async_valid_x0", v0x, 0); chk("async_err1", e1, 0);
        q1.delete(); q0.delete();
        k_m = 0; err_edge = c_inf;
        ce = 1'b0; va = 1'b0; vb = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        step(1, 1, 1, 10, 0, 6, 0);
        rnd_steps(60, 1'b1);

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
        chk("drain_scaled", q1.size(), 0);
        chk("drain_unscaled", q0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
